// File: rtl/alu_flag_reg.sv
// Registered Z80 flag unit: computes S/Z/Y/H/X/PV/N/C per op class, holds F and shadow F'.
// Define ALU_FLAGS_UNDOC_XY_EN to drive the undocumented Y/X bits from the source operand.
module alu_flag_reg #(
    parameter int ALU_WIDTH = 8,
    parameter int HALF_BIT  = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [ALU_WIDTH-1:0] a,
    input  logic [ALU_WIDTH-1:0] b,
    input  logic [ALU_WIDTH-1:0] op_result,
    input  logic [ALU_WIDTH:0]   result_buffer,
    input  logic [2:0]           opcode,
    input  logic                 op_sign,
    input  logic                 use_carry,
    input  logic                 upd_valid,
    input  logic [7:0]           upd_mask,
    input  logic                 f_load,
    input  logic [7:0]           f_load_data,
    input  logic                 ex_af,
    output logic [7:0]           f_q,
    output logic [7:0]           f_shadow_q,
    output logic                 flags_valid,
    output logic                 illegal_op
);
    localparam int MSB = ALU_WIDTH - 1;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0, OP_SUB = 3'd1, OP_SHIFT = 3'd2, OP_LOGIC = 3'd3,
        OP_CMP = 3'd4, OP_INCDEC = 3'd5, OP_CARRY = 3'd6, OP_ILL = 3'd7
    } op_e;

    logic [7:0]           f_d, f_shadow_d, new_f;
    logic                 flags_valid_d, illegal_op_d;
    logic                 cin, is_sub, half_flag, ovf, y_bit, x_bit;
    logic [ALU_WIDTH-1:0] b_eff, xy_src;
    logic [HALF_BIT:0]    half_sum;

    always_comb begin
        b_eff  = (opcode == OP_INCDEC) ? ALU_WIDTH'(1) : b;
        cin    = (opcode == OP_INCDEC) ? 1'b0 : (use_carry & f_q[0]);
        is_sub = (opcode == OP_SUB) || (opcode == OP_CMP) || ((opcode == OP_INCDEC) && op_sign);
        // Extra top bit holds the carry/borrow out of the low nibble.
        if (is_sub)
            half_sum = {1'b0, a[HALF_BIT-1:0]} - {1'b0, b_eff[HALF_BIT-1:0]} - (HALF_BIT+1)'(cin);
        else
            half_sum = {1'b0, a[HALF_BIT-1:0]} + {1'b0, b_eff[HALF_BIT-1:0]} + (HALF_BIT+1)'(cin);
        half_flag = half_sum[HALF_BIT];
        if (is_sub)
            ovf = (a[MSB] != b_eff[MSB]) && (op_result[MSB] != a[MSB]);
        else
            ovf = (a[MSB] == b_eff[MSB]) && (op_result[MSB] != a[MSB]);

        xy_src = (opcode == OP_CMP) ? b : op_result;
`ifdef ALU_FLAGS_UNDOC_XY_EN
        y_bit = xy_src[5];
        x_bit = xy_src[3];
`else
        y_bit = 1'b0;
        x_bit = 1'b0;
`endif

        new_f    = f_q;
        new_f[7] = op_result[MSB];
        new_f[6] = (op_result == '0);
        new_f[5] = y_bit;
        new_f[3] = x_bit;
        unique case (op_e'(opcode))
            OP_ADD, OP_SUB, OP_CMP: begin
                new_f[4] = half_flag;
                new_f[2] = ovf;
                new_f[1] = is_sub;
                new_f[0] = result_buffer[ALU_WIDTH];
            end
            OP_INCDEC: begin
                new_f[4] = half_flag;
                new_f[2] = ovf;
                new_f[1] = is_sub;
                new_f[0] = f_q[0];
            end
            OP_SHIFT: begin
                new_f[4] = 1'b0;
                new_f[2] = ~^op_result;
                new_f[1] = 1'b0;
                new_f[0] = op_sign ? result_buffer[0] : result_buffer[ALU_WIDTH];
            end
            OP_LOGIC: begin
                new_f[4] = ~op_sign;
                new_f[2] = ~^op_result;
                new_f[1] = 1'b0;
                new_f[0] = 1'b0;
            end
            OP_CARRY: begin
                // SCF/CCF leave S, Z and PV alone.
                new_f[7] = f_q[7];
                new_f[6] = f_q[6];
                new_f[2] = f_q[2];
                new_f[4] = op_sign & f_q[0];
                new_f[1] = 1'b0;
                new_f[0] = op_sign ? ~f_q[0] : 1'b1;
            end
            default: new_f = f_q;
        endcase
    end

    always_comb begin
        f_d           = f_q;
        f_shadow_d    = f_shadow_q;
        flags_valid_d = 1'b0;
        illegal_op_d  = 1'b0;
        if (f_load) begin
            f_d           = f_load_data;
            flags_valid_d = 1'b1;
        end else if (ex_af) begin
            f_d           = f_shadow_q;
            f_shadow_d    = f_q;
            flags_valid_d = 1'b1;
        end else if (upd_valid) begin
            if (opcode == OP_ILL) begin
                illegal_op_d = 1'b1;
            end else begin
                f_d           = (upd_mask & new_f) | (~upd_mask & f_q);
                flags_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            f_q         <= 8'h00;
            f_shadow_q  <= 8'h00;
            flags_valid <= 1'b0;
            illegal_op  <= 1'b0;
        end else begin
            f_q         <= f_d;
            f_shadow_q  <= f_shadow_d;
            flags_valid <= flags_valid_d;
            illegal_op  <= illegal_op_d;
        end
    end
endmodule

// File: tb/tb_alu_flag_reg.sv
// Directed vector bench for alu_flag_reg (default build: Y/X written as 0).
module tb_alu_flag_reg;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] a, b, op_result, upd_mask, f_load_data;
    logic [8:0] result_buffer;
    logic [2:0] opcode;
    logic       op_sign, use_carry, upd_valid, f_load, ex_af;
    logic [7:0] f_q, f_shadow_q;
    logic       flags_valid, illegal_op;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_flag_reg #(.ALU_WIDTH(8), .HALF_BIT(4)) dut (
        .clk(clk), .reset_n(reset_n), .a(a), .b(b), .op_result(op_result),
        .result_buffer(result_buffer), .opcode(opcode), .op_sign(op_sign),
        .use_carry(use_carry), .upd_valid(upd_valid), .upd_mask(upd_mask),
        .f_load(f_load), .f_load_data(f_load_data), .ex_af(ex_af),
        .f_q(f_q), .f_shadow_q(f_shadow_q), .flags_valid(flags_valid),
        .illegal_op(illegal_op)
    );

    typedef struct {
        logic       ld;
        logic [7:0] ld_data;
        logic       ex;
        logic       upd;
        logic [7:0] mask;
        logic [2:0] opc;
        logic       sgn;
        logic       uc;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic [8:0] rbuf;
        logic [7:0] ef;
        logic [7:0] esh;
        logic       efv;
        logic       eill;
    } vec_t;

    vec_t vecs[23];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        a = 8'h00; b = 8'h00; op_result = 8'h00; result_buffer = 9'h000;
        opcode = 3'd0; op_sign = 1'b0; use_carry = 1'b0; upd_valid = 1'b0;
        upd_mask = 8'h00; f_load = 1'b0; f_load_data = 8'h00; ex_af = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Sequence: flag state carries from one vector into the next.
        vecs[0]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hFF, 3'd0, 1'b0, 1'b0, 8'h7F, 8'h01, 8'h80, 9'h080, 8'h94, 8'h00, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hFF, 3'd1, 1'b0, 1'b0, 8'h00, 8'h01, 8'hFF, 9'h1FF, 8'h93, 8'h00, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hFF, 3'd0, 1'b0, 1'b1, 8'h01, 8'h01, 8'h03, 9'h003, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hFF, 3'd6, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 9'h000, 8'h01, 8'h00, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hFF, 3'd0, 1'b0, 1'b1, 8'h0F, 8'h00, 8'h10, 9'h010, 8'h10, 8'h00, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hFF, 3'd2, 1'b1, 1'b0, 8'h06, 8'h00, 8'h03, 9'h003, 8'h05, 8'h00, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hFF, 3'd2, 1'b0, 1'b0, 8'hC0, 8'h00, 8'h80, 9'h180, 8'h81, 8'h00, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hFF, 3'd3, 1'b0, 1'b0, 8'hF0, 8'h0F, 8'h00, 9'h000, 8'h54, 8'h00, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hFF, 3'd3, 1'b1, 1'b0, 8'h01, 8'h02, 8'h03, 9'h003, 8'h04, 8'h00, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hFF, 3'd4, 1'b0, 1'b0, 8'h10, 8'h20, 8'hF0, 9'h1F0, 8'h83, 8'h00, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 9'h000, 8'h83, 8'h00, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h40, 3'd0, 1'b0, 1'b0, 8'hFF, 8'h01, 8'h00, 9'h100, 8'hC3, 8'h00, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 8'hD7, 1'b1, 1'b1, 8'hFF, 3'd0, 1'b0, 1'b0, 8'h01, 8'h01, 8'h02, 9'h002, 8'hD7, 8'h00, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 9'h000, 8'h00, 8'hD7, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hFF, 3'd3, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 9'h000, 8'hD7, 8'h00, 1'b1, 1'b0};
        vecs[15] = '{1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 9'h000, 8'h01, 8'h00, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hFF, 3'd6, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 9'h000, 8'h10, 8'h00, 1'b1, 1'b0};
        vecs[17] = '{1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 9'h000, 8'h01, 8'h00, 1'b1, 1'b0};
        vecs[18] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hFF, 3'd5, 1'b0, 1'b0, 8'hFF, 8'h00, 8'h00, 9'h100, 8'h51, 8'h00, 1'b1, 1'b0};
        vecs[19] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hFF, 3'd5, 1'b1, 1'b0, 8'h80, 8'h00, 8'h7F, 9'h07F, 8'h17, 8'h00, 1'b1, 1'b0};
        vecs[20] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hFF, 3'd7, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 9'h000, 8'h17, 8'h00, 1'b0, 1'b1};
        vecs[21] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 9'h000, 8'h17, 8'h00, 1'b0, 1'b0};
        vecs[22] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hFF, 3'd7, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 9'h000, 8'h00, 8'h17, 1'b1, 1'b0};

        idle_inputs();
        reset_n = 1'b0;
        #12;
        chk("reset_f", f_q, 8'h00);
        chk("reset_fsh", f_shadow_q, 8'h00);
        chk("reset_fv", {7'b0, flags_valid}, 8'h00);
        chk("reset_ill", {7'b0, illegal_op}, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 23; i++) begin
            f_load = vecs[i].ld;  f_load_data = vecs[i].ld_data; ex_af = vecs[i].ex;
            upd_valid = vecs[i].upd; upd_mask = vecs[i].mask; opcode = vecs[i].opc;
            op_sign = vecs[i].sgn; use_carry = vecs[i].uc; a = vecs[i].a; b = vecs[i].b;
            op_result = vecs[i].res; result_buffer = vecs[i].rbuf;
            step();
            chk($sformatf("v%0d_f", i), f_q, vecs[i].ef);
            chk($sformatf("v%0d_fsh", i), f_shadow_q, vecs[i].esh);
            chk($sformatf("v%0d_fv", i), {7'b0, flags_valid}, {7'b0, vecs[i].efv});
            chk($sformatf("v%0d_ill", i), {7'b0, illegal_op}, {7'b0, vecs[i].eill});
        end

        // Reset landing mid-cycle while an update is pending clears everything at once.
        idle_inputs();
        f_load = 1'b1; f_load_data = 8'hFF; step();
        f_load = 1'b0; ex_af = 1'b1; step();
        ex_af = 1'b0; f_load = 1'b1; f_load_data = 8'hAA; step();
        chk("pre_reset_f", f_q, 8'hAA);
        chk("pre_reset_fsh", f_shadow_q, 8'hFF);
        f_load = 1'b0; upd_valid = 1'b1; upd_mask = 8'hFF; opcode = 3'd0;
        a = 8'h7F; b = 8'h01; op_result = 8'h80; result_buffer = 9'h080;
        #2;
        reset_n = 1'b0;
        #1;
        chk("midreset_f", f_q, 8'h00);
        chk("midreset_fsh", f_shadow_q, 8'h00);
        chk("midreset_fv", {7'b0, flags_valid}, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        chk("post_reset_f", f_q, 8'h94);
        chk("post_reset_fv", {7'b0, flags_valid}, 8'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
